// File: rtl/pseudo_linear_pkg.sv
// pseudo_linear_pkg: shared FSM encoding, size defaults and forward decision rule.
package pseudo_linear_pkg;
   localparam int N_IN_DEF  = 784;
   localparam int CHUNK_DEF = 16;
   typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DECIDE, S_UPDATE, S_RESP} state_t;
   // Any threshold at or beyond the counter width shifts b to zero, so a plain shift suffices.
   function automatic logic forward(input logic [31:0] a, input logic [31:0] b, input logic [3:0] th);
      return (b >> th) < a;
   endfunction
endpackage

// File: rtl/pseudo_linear_chunk_eval.sv
// pseudo_linear_chunk_eval: popcounts and single-bit probe flip mask for one parameter chunk.
module pseudo_linear_chunk_eval import pseudo_linear_pkg::*; #(
   parameter int CHUNK = CHUNK_DEF,
   parameter int CW = 10,
   localparam int PW = $clog2(CHUNK + 1)
) (
   input  logic [CHUNK-1:0] p,
   input  logic [CHUNK-1:0] img,
   input  logic [CW-1:0]    num,
   input  logic [CW-1:0]    num_p,
   input  logic             result,
   input  logic [3:0]       threshold,
   output logic [PW-1:0]    cnt_and,
   output logic [PW-1:0]    cnt_p,
   output logic [CHUNK-1:0] flip
);
   always_comb begin
      cnt_and = '0;
      cnt_p = '0;
      for (int i = 0; i < CHUNK; i++) begin
         cnt_and = cnt_and + PW'(p[i] & img[i]);
         cnt_p = cnt_p + PW'(p[i]);
      end
   end
   for (genvar m = 0; m < CHUNK; m++) begin : g_bit
      logic [CW-1:0] num_r, num_p_r;
      assign num_r = img[m] ? (p[m] ? num - 1'b1 : num + 1'b1) : num;
      assign num_p_r = p[m] ? num_p - 1'b1 : num_p + 1'b1;
      assign flip[m] = forward(32'(num_r), 32'(num_p_r), threshold) != result;
   end
endmodule

// File: rtl/pseudo_linear_seq.sv
// pseudo_linear_seq: chunk-serial popcount classifier with single-bit-probe parameter training.
module pseudo_linear_seq import pseudo_linear_pkg::*; #(
   parameter int N_IN = N_IN_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N_IN-1:0] image,
   input  logic            label,
   input  logic [3:0]      threshold,
   input  logic            train_en,
   input  logic            p_clear,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            result,
   output logic            error,
   output logic [N_IN-1:0] pm
);
   localparam int NCH = N_IN / CHUNK;
   localparam int CW = $clog2(N_IN + 2);
   localparam int PW = $clog2(CHUNK + 1);
   localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
   state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] num_q, num_d, num_p_q, num_p_d;
   logic [N_IN-1:0] p_q, p_d, img_q, img_d;
   logic [3:0] thr_q, thr_d;
   logic label_q, label_d, train_q, train_d, result_q, result_d, error_q, error_d;
   logic [CHUNK-1:0] p_c, img_c, flip;
   logic [PW-1:0] cnt_and, cnt_p;
   logic last;
   assign p_c = p_q[int'(idx_q)*CHUNK +: CHUNK];
   assign img_c = img_q[int'(idx_q)*CHUNK +: CHUNK];
   assign last = idx_q == IW'(NCH - 1);
   pseudo_linear_chunk_eval #(.CHUNK(CHUNK), .CW(CW)) u_eval (
      .p(p_c),
      .img(img_c),
      .num(num_q),
      .num_p(num_p_q),
      .result(result_q),
      .threshold(thr_q),
      .cnt_and(cnt_and),
      .cnt_p(cnt_p),
      .flip(flip)
   );
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      num_d = num_q;
      num_p_d = num_p_q;
      p_d = p_q;
      img_d = img_q;
      thr_d = thr_q;
      label_d = label_q;
      train_d = train_q;
      result_d = result_q;
      error_d = error_q;
      case (state_q)
         S_IDLE:
            if (p_clear) p_d = '0;
            else if (in_valid) begin
               img_d = image;
               label_d = label;
               thr_d = threshold;
               train_d = train_en;
               idx_d = '0;
               num_d = '0;
               num_p_d = '0;
               state_d = S_COUNT;
            end
         S_COUNT: begin
            num_d = num_q + CW'(cnt_and);
            num_p_d = num_p_q + CW'(cnt_p);
            idx_d = last ? '0 : idx_q + 1'b1;
            state_d = last ? S_DECIDE : S_COUNT;
         end
         S_DECIDE: begin
            result_d = forward(32'(num_q), 32'(num_p_q), thr_q);
            error_d = result_d ^ label_q;
            state_d = train_q && error_d ? S_UPDATE : S_RESP;
         end
         // num/num_p stay frozen here, so each chunk's flips are independent of earlier ones.
         S_UPDATE: begin
            p_d[int'(idx_q)*CHUNK +: CHUNK] = p_c ^ flip;
            idx_d = last ? '0 : idx_q + 1'b1;
            state_d = last ? S_RESP : S_UPDATE;
         end
         S_RESP: state_d = out_ready ? S_IDLE : S_RESP;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q <= '0;
         num_q <= '0;
         num_p_q <= '0;
         p_q <= '0;
         img_q <= '0;
         thr_q <= '0;
         label_q <= 1'b0;
         train_q <= 1'b0;
         result_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         num_q <= num_d;
         num_p_q <= num_p_d;
         p_q <= p_d;
         img_q <= img_d;
         thr_q <= thr_d;
         label_q <= label_d;
         train_q <= train_d;
         result_q <= result_d;
         error_q <= error_d;
      end
   end
   assign in_ready = state_q == S_IDLE;
   assign out_valid = state_q == S_RESP;
   assign result = result_q;
   assign error = error_q;
   assign pm = p_q;
endmodule

// File: tb/tb_pseudo_linear_seq.sv
// tb_pseudo_linear_seq: directed and randomized checks against a bit-level reference model.
module tb_pseudo_linear_seq;
   localparam int N = 784;
   localparam int NCH = N / 16;
   logic clk = 0, rst_n = 0, in_valid = 0, label = 0, train_en = 0, p_clear = 0, out_ready = 0;
   logic [N-1:0] image = '0;
   logic [3:0] threshold = '0;
   logic in_ready, out_valid, result, error;
   logic [N-1:0] pm;
   logic [N-1:0] p_m = '0;
   int errors = 0, checks = 0;

   pseudo_linear_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .image(image),
      .label(label), .threshold(threshold), .train_en(train_en), .p_clear(p_clear),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .error(error), .pm(pm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int popc(input logic [N-1:0] v);
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(v[i]);
      return c;
   endfunction

   function automatic bit fwd(input int a, input int b, input int th);
      return ((b >> th) >= a) ? 1'b0 : 1'b1;
   endfunction

   task automatic run(input logic [N-1:0] img, input bit lab, input int th, input bit tr, input int hold);
      int num, nump, lat, exp_lat;
      bit res, err;
      logic [N-1:0] p_new;
      num = popc(p_m & img);
      nump = popc(p_m);
      res = fwd(num, nump, th);
      err = res ^ lab;
      p_new = p_m;
      if (tr && err)
         for (int m = 0; m < N; m++) begin
            int nr, npr;
            nr = img[m] ? (p_m[m] ? num - 1 : num + 1) : num;
            npr = p_m[m] ? nump - 1 : nump + 1;
            if (fwd(nr, npr, th) != res) p_new[m] = ~p_m[m];
         end
      exp_lat = (tr && err) ? 2 * NCH + 2 : NCH + 2;
      chk("in_ready_idle", N'(in_ready), N'(1));
      image = img; label = lab; threshold = 4'(th); train_en = tr; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      lat = 1;
      while (!out_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", N'(lat), N'(exp_lat));
      chk("result", N'(result), N'(res));
      chk("error", N'(error), N'(err));
      chk("pm", pm, p_new);
      p_m = p_new;
      for (int k = 0; k < hold; k++) begin
         in_valid = 1;
         @(posedge clk); #1;
         chk("bp_out_valid", N'(out_valid), N'(1));
         chk("bp_result", N'(result), N'(res));
         chk("bp_error", N'(error), N'(err));
         chk("bp_in_ready", N'(in_ready), N'(0));
      end
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("idle_after_resp", N'(in_ready), N'(1));
      chk("out_valid_dropped", N'(out_valid), N'(0));
      chk("pm_after_resp", pm, p_m);
   endtask

   task automatic clear_params();
      p_clear = 1; in_valid = 1; image = '1;
      @(posedge clk); #1;
      p_clear = 0; in_valid = 0;
      p_m = '0;
      chk("clear_pm", pm, '0);
      chk("clear_no_accept", N'(in_ready), N'(1));
   endtask

   initial begin
      logic [N-1:0] img;
      bit saw_ov;
      #23 rst_n = 1;
      @(posedge clk); #1;
      chk("reset_pm", pm, '0);
      chk("reset_out_valid", N'(out_valid), N'(0));
      chk("reset_in_ready", N'(in_ready), N'(1));
      run('1, 1, 1, 1, 0);
      chk("full_update_all_ones", pm, '1);
      run('1, 1, 1, 1, 0);
      clear_params();
      run('1, 1, 1, 0, 0);
      clear_params();
      run('1, 1, 1, 1, 10);
      for (int t = 0; t < 24; t++) begin
         int dens;
         dens = $urandom_range(0, 100);
         for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 99) < dens;
         run(img, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'($urandom_range(0, 3) != 0),
             $urandom_range(0, 2));
      end
      clear_params();
      image = '1; label = 1; threshold = 4'd1; train_en = 1; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (20) @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("midop_rst_in_ready", N'(in_ready), N'(1));
      chk("midop_rst_pm", pm, '0);
      chk("midop_rst_out_valid", N'(out_valid), N'(0));
      @(posedge clk); #1;
      rst_n = 1;
      p_m = '0;
      saw_ov = 0;
      repeat (2 * NCH + 10) begin
         @(posedge clk); #1;
         saw_ov |= out_valid;
      end
      chk("midop_no_out_valid", N'(saw_ov), N'(0));
      chk("midop_idle", N'(in_ready), N'(1));
      chk("midop_pm_zero", pm, '0);
      run('1, 1, 1, 1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pseudo_linear_seq.md
PSEUDO_LINEAR_SEQ -- requirements
Module: pseudo_linear_seq

Interface
REQ-001 SHALL have parameter N_IN, default 784, number of input features / parameter bits.
REQ-002 SHALL have parameter CHUNK, default 16, bits processed per cycle; N_IN SHALL be a multiple of CHUNK (NCH = N_IN/CHUNK, 49 by default).
REQ-003 SHALL have local constant CW = clog2(N_IN+2), the counter width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  sample offered.
REQ-007 in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-008 image  input  N_IN  binary feature vector.
REQ-009 label  input  1  target class bit.
REQ-010 threshold  input  4  right-shift applied to the parameter popcount.
REQ-011 train_en  input  1  when 1, a misclassified sample updates the parameters.
REQ-012 p_clear  input  1  synchronous clear of all parameters, honoured only in IDLE.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-015 result  output  1  forward prediction.
REQ-016 error  output  1  result XOR label.
REQ-017 pm  output  N_IN  current parameter vector p.

Function
REQ-018 FSM states: IDLE, COUNT, DECIDE, UPDATE, RESP; in_ready SHALL be 1 exactly in IDLE.
REQ-019 On acceptance, image, label, threshold and train_en SHALL be latched and the FSM SHALL enter COUNT with the chunk index at 0; in_valid SHALL be ignored outside IDLE.
REQ-020 Chunk counting: COUNT SHALL take NCH cycles, accumulating per cycle num += popcount(p & img chunk) and num_p += popcount(p chunk).
REQ-021 Forward rule: forward(a, b) SHALL be 0 if (b >> threshold) >= a, else 1; a shift of threshold >= CW SHALL yield 0.
REQ-022 DECIDE (1 cycle) SHALL register result = forward(num, num_p) and error = result ^ label.
REQ-023 Exit from DECIDE: if train_en && error, the FSM SHALL go to UPDATE; otherwise it SHALL go to RESP.
REQ-024 Probe values: UPDATE SHALL take NCH cycles and, for each bit m of the current chunk, form:
 - num_r = img[m] ? (p[m] ? num-1 : num+1) : num
 - num_p_r = p[m] ? num_p-1 : num_p+1
REQ-025 Flip rule: p[m] SHALL flip iff forward(num_r, num_p_r) != result, with num and num_p frozen from COUNT, so bit order does not matter.
REQ-026 Counter width: num and num_p SHALL be CW bits wide, so no wrap occurs (num-1 only when num >= 1; num_p+1 <= N_IN+1).
REQ-027 In RESP, out_valid SHALL be 1 and result/error SHALL be held until out_ready; on that handshake the FSM SHALL return to IDLE.
REQ-028 Latency from the acceptance edge to out_valid SHALL be NCH+2 cycles without update and 2*NCH+2 cycles with update; pm SHALL reflect all flips when out_valid rises.
REQ-029 p SHALL change only in UPDATE or via p_clear in IDLE; p_clear SHALL take priority over acceptance in the same cycle, with no sample accepted that cycle.

Reset
REQ-030 On rst_n low, asynchronously: state = IDLE, p = 0, num = num_p = 0, chunk index = 0, out_valid = 0, result = 0, error = 0; in_ready reads 1 after reset.
REQ-031 A reset mid-COUNT, DECIDE, UPDATE or RESP SHALL abort the operation, discard the sample and partial flips, and emit no out_valid.

Structure
REQ-032 Package pseudo_linear_pkg SHALL hold the FSM state encoding, the defaults for N_IN and CHUNK, and the forward function.
REQ-033 Sub-module pseudo_linear_chunk_eval SHALL compute, for one CHUNK slice, both popcounts and the CHUNK-bit flip mask from num, num_p, result and threshold.

Verification
REQ-034 Reset: after rst_n release -> pm = 0, out_valid = 0, in_ready = 1.
REQ-035 Full update: p = 0, image all ones, label = 1, threshold = 1, train_en = 1 -> result = 0, error = 1, out_valid 100 cycles after acceptance, pm all ones.
REQ-036 Correct sample: repeat REQ-035's sample -> num = num_p = 784, 392 < 784, so result = 1, error = 0, out_valid after 51 cycles, pm unchanged.
REQ-037 Inference only: REQ-035's stimulus with train_en = 0 -> error = 1, out_valid after 51 cycles, pm stays 0.
REQ-038 Backpressure: hold out_ready = 0 for 10 cycles with in_valid = 1 -> out_valid, result and error stable, in_ready = 0, no second acceptance; returns to IDLE one cycle after out_ready.
REQ-039 Reset mid-op: rst_n low at COUNT cycle 20 during a training sample -> IDLE, pm = 0, out_valid never asserted for that sample.
